psum_out_stage: RTL and testbench

PSUM_OUT_STAGE -- requirements
Module: psum_out_stage

---
 rtl/psum_out_stage_pkg.sv | 17 +
 rtl/psum_out_stage_requant.sv | 34 +++
 rtl/psum_out_stage.sv | 176 +++++++++++++++++
 tb/tb_psum_out_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_out_stage_pkg.sv
// Shared widths, FSM encoding and small helpers for the partial-sum output stage.
package psum_out_stage_pkg;
  localparam int PSUM_W_DEF = 32;
  localparam int BIAS_W_DEF = 16;
  localparam int OUT_W_DEF  = 8;
  localparam int SHIFT_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/psum_out_stage_requant.sv
// Combinational requantiser: bias add, round-half-up arithmetic shift, ReLU + saturate.
module requant_relu
  import psum_out_stage_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int BIAS_W = BIAS_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
)(
  input  logic [PSUM_W-1:0]  i_psum,
  input  logic [BIAS_W-1:0]  i_bias,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [OUT_W-1:0]   o_act
);
  // Two guard bits keep psum + bias + rounding term free of overflow.
  localparam int EW = PSUM_W + 2;

  logic signed [EW-1:0] w_psum_x;
  logic signed [EW-1:0] w_bias_x;
  logic signed [EW-1:0] w_rnd;
  logic signed [EW-1:0] w_sum;
  logic signed [EW-1:0] w_shf;

  assign w_psum_x = {{2{i_psum[PSUM_W-1]}}, i_psum};
  assign w_bias_x = {{(EW-BIAS_W){i_bias[BIAS_W-1]}}, i_bias};
  assign w_rnd    = (i_shift == '0) ? '0 : (EW'(1) <<< (i_shift - SHIFT_W'(1)));
  assign w_sum    = w_psum_x + w_bias_x + w_rnd;
  assign w_shf    = w_sum >>> i_shift;

  always_comb begin
    o_act = w_shf[OUT_W-1:0];
    if (w_shf[EW-1])               o_act = '0;
    else if (|w_shf[EW-2:OUT_W])   o_act = '1;
  end
endmodule

// File: rtl/psum_out_stage.sv
// Accumulates PE partial sums across channel groups, then drains them requantised.
module psum_out_stage
  import psum_out_stage_pkg::*;
#(
  parameter int PE_COLS    = 8,
  parameter int KERNEL_NUM = 2,
  parameter int PSUM_W     = PSUM_W_DEF,
  parameter int BIAS_W     = BIAS_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  localparam int BA_W      = clog2_min1(KERNEL_NUM)
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PSUM_W-1:0]  in_data,
  input  logic               first_grp,
  input  logic               last_grp,
  input  logic               bias_we,
  input  logic [BA_W-1:0]    bias_addr,
  input  logic [BIAS_W-1:0]  bias_data,
  input  logic [SHIFT_W-1:0] shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               busy,
  output logic               done
);
  localparam int DEPTH  = PE_COLS * KERNEL_NUM;
  localparam int IDX_W  = clog2_min1(DEPTH);
  localparam int COL_W  = clog2_min1(PE_COLS);
  localparam int BIAS_N = 1 << BA_W;

  state_e r_state, w_state_nx;

  logic [IDX_W-1:0]  r_widx, r_ridx, w_raddr;
  logic [COL_W-1:0]  r_rcol;
  logic [BA_W-1:0]   r_rk;
  logic              r_first, r_last, r_rd_done, r_ov, r_done;
  logic [OUT_W-1:0]  r_od;
  logic [PSUM_W-1:0] r_buf [DEPTH];
  logic [BIAS_W-1:0] r_bias [BIAS_N];

  logic              w_in_ready, w_acc_we, w_load, w_done_evt;
  logic              w_first_eff, w_last_eff, w_widx_end, w_ridx_end;
  logic [PSUM_W-1:0] w_rdata;
  logic [OUT_W-1:0]  w_act;

  // Group flags travel with word 0; later words use the latched copy.
  assign w_first_eff = (r_state == ST_IDLE) ? first_grp : r_first;
  assign w_last_eff  = (r_state == ST_IDLE) ? last_grp  : r_last;
  assign w_widx_end  = (r_widx == IDX_W'(DEPTH-1));
  assign w_ridx_end  = (r_ridx == IDX_W'(DEPTH-1));

  // Accumulate and drain never overlap, so one read port serves both.
  assign w_raddr = (r_state == ST_DRAIN) ? r_ridx : r_widx;
  assign w_rdata = r_buf[w_raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_in_ready = 1'b0;
    w_acc_we   = 1'b0;
    w_load     = 1'b0;
    w_done_evt = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACC: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_acc_we = 1'b1;
          if (w_widx_end) begin
            if (w_last_eff) w_state_nx = ST_DRAIN;
            else begin
              w_state_nx = ST_IDLE;
              w_done_evt = 1'b1;
            end
          end else begin
            w_state_nx = ST_ACC;
          end
        end
      end
      ST_DRAIN: begin
        w_load = !r_rd_done && (!r_ov || out_ready);
        if (r_ov && out_ready && r_rd_done) begin
          w_state_nx = ST_IDLE;
          w_done_evt = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_acc_we)
      r_buf[r_widx] <= w_first_eff ? in_data : w_rdata + in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_widx  <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_acc_we) begin
      r_widx <= w_widx_end ? '0 : r_widx + IDX_W'(1);
      if (r_state == ST_IDLE) begin
        r_first <= first_grp;
        r_last  <= last_grp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BIAS_N; i++) r_bias[i] <= '0;
    end else if (bias_we) begin
      r_bias[bias_addr] <= bias_data;
    end
  end

  requant_relu #(
    .PSUM_W (PSUM_W),
    .BIAS_W (BIAS_W),
    .OUT_W  (OUT_W)
  ) u_requant (
    .i_psum  (w_rdata),
    .i_bias  (r_bias[r_rk]),
    .i_shift (shift),
    .o_act   (w_act)
  );

  // Read side: column/kernel counters run beside the index to avoid a divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ridx    <= '0;
      r_rcol    <= '0;
      r_rk      <= '0;
      r_rd_done <= 1'b0;
      r_ov      <= 1'b0;
      r_od      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_done_evt;
      if (w_load) begin
        r_od <= w_act;
        r_ov <= 1'b1;
        if (w_ridx_end) begin
          r_ridx    <= '0;
          r_rcol    <= '0;
          r_rk      <= '0;
          r_rd_done <= 1'b1;
        end else begin
          r_ridx <= r_ridx + IDX_W'(1);
          if (r_rcol == COL_W'(PE_COLS-1)) begin
            r_rcol <= '0;
            r_rk   <= r_rk + BA_W'(1);
          end else begin
            r_rcol <= r_rcol + COL_W'(1);
          end
        end
      end else if (out_ready) begin
        r_ov <= 1'b0;
      end
      if (w_done_evt && r_state == ST_DRAIN) r_rd_done <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_ov;
  assign out_data  = r_od;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
endmodule

// File: tb/tb_psum_out_stage.sv
// Randomised bench for psum_out_stage against a queue-based behavioural model.
module tb_psum_out_stage;
  localparam int PE_COLS    = 8;
  localparam int KERNEL_NUM = 2;
  localparam int DEPTH      = PE_COLS * KERNEL_NUM;
  localparam int PSUM_W     = 32;
  localparam int BIAS_W     = 16;
  localparam int OUT_W      = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PSUM_W-1:0] in_data = '0;
  logic              first_grp = 1'b0, last_grp = 1'b0;
  logic              bias_we = 1'b0;
  logic [0:0]        bias_addr = '0;
  logic [BIAS_W-1:0] bias_data = '0;
  logic [4:0]        shift = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic              busy, done;

  psum_out_stage #(.PE_COLS(PE_COLS), .KERNEL_NUM(KERNEL_NUM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .first_grp(first_grp), .last_grp(last_grp),
    .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
    .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_done = 0, n_done_exp = 0;
  int rdy_mode = 0, bp_ph = 0;
  int mbias [KERNEL_NUM];
  int mshift = 0;
  logic [PSUM_W-1:0] mbuf [DEPTH];
  logic [PSUM_W-1:0] wdat [DEPTH];
  logic [OUT_W-1:0]  exp_q [$];
  logic [OUT_W-1:0]  got_q [$];
  logic              prev_stall = 1'b0;
  logic [OUT_W-1:0]  prev_data = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference requantiser in plain 64-bit arithmetic.
  function automatic logic [OUT_W-1:0] ref_act(input logic [PSUM_W-1:0] p, input int b, input int s);
    longint v;
    v = longint'($signed(p)) + longint'(b);
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (v < 0) return '0;
    if (v > 255) return 8'd255;
    return OUT_W'(v);
  endfunction

  // Downstream ready patterns: always, random, or the 1,0,0,1 stall pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = (bp_ph == 0 || bp_ph == 3);
          bp_ph = (bp_ph + 1) % 4;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (done) n_done++;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid) chk("in_ready_drain", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_extra: got %0d expected none", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
        got_q.push_back(out_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic wr_bias(input int k, input int v);
    bias_we = 1'b1; bias_addr = 1'(k); bias_data = 16'(v);
    @(posedge clk); #1;
    bias_we = 1'b0;
    mbias[k] = v;
  endtask

  // Sends one batch; abort_at >= 0 pulls reset just before that word.
  task automatic send_batch(input bit f, input bit l, input int abort_at);
    int i, guard;
    bit ff;
    i = 0; guard = 0; ff = 1'b0;
    while (i < DEPTH) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        for (int k = 0; k < KERNEL_NUM; k++) mbias[k] = 0;
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        return;
      end
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid  = 1'b1;
        in_data   = wdat[i];
        first_grp = (i == 0) ? f : 1'($urandom);
        last_grp  = (i == 0) ? l : 1'($urandom);
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (i == 0) ff = f;
        mbuf[i] = ff ? wdat[i] : mbuf[i] + wdat[i];
        i++;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        chk("in_accept_timeout", i, DEPTH);
        break;
      end
    end
    in_valid = 1'b0;
    if (i == DEPTH) begin
      n_done_exp++;
      if (l)
        for (int j = 0; j < DEPTH; j++)
          exp_q.push_back(ref_act(mbuf[j], mbias[j / PE_COLS], mshift));
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_in_time", (g < 3000) ? 1 : 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("done_count", n_done, n_done_exp);
  endtask

  task automatic set_shift(input int s);
    mshift = s;
    shift  = 5'(s);
  endtask

  initial begin
    int d0;
    for (int k = 0; k < KERNEL_NUM; k++) mbias[k] = 0;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", in_ready, 1);

    // Single group, two biases, identity data.
    wr_bias(0, 10); wr_bias(1, -5); set_shift(0);
    for (int j = 0; j < DEPTH; j++) wdat[j] = PSUM_W'(j);
    got_q.delete(); d0 = n_done;
    send_batch(1, 1, -1);
    wait_drain();
    chk("t_single_count", got_q.size(), DEPTH);
    for (int j = 0; j < DEPTH && j < got_q.size(); j++)
      chk("t_single_lit", got_q[j], (j < 8) ? 10 + j : j - 5);
    chk("t_single_done", n_done - d0, 1);

    // Three groups of ones, rounding shift of 1.
    wr_bias(0, 0); wr_bias(1, 0); set_shift(1);
    for (int j = 0; j < DEPTH; j++) wdat[j] = 32'd1;
    got_q.delete(); d0 = n_done;
    send_batch(1, 0, -1); send_batch(0, 0, -1); send_batch(0, 1, -1);
    wait_drain();
    chk("t_groups_count", got_q.size(), DEPTH);
    for (int j = 0; j < got_q.size(); j++) chk("t_groups_lit", got_q[j], 2);
    chk("t_groups_done", n_done - d0, 3);

    // Saturation both ways.
    set_shift(0);
    for (int j = 0; j < DEPTH; j++) wdat[j] = (j % 2 == 0) ? 32'd1000 : -32'sd1000;
    got_q.delete();
    send_batch(1, 1, -1);
    wait_drain();
    chk("t_sat_count", got_q.size(), DEPTH);
    for (int j = 0; j < got_q.size(); j++) chk("t_sat_lit", got_q[j], (j % 2 == 0) ? 255 : 0);

    // Back-pressure 1,0,0,1.
    rdy_mode = 2; set_shift(2);
    wr_bias(0, 37); wr_bias(1, -90);
    for (int j = 0; j < DEPTH; j++) wdat[j] = PSUM_W'($urandom_range(0, 1200));
    got_q.delete();
    send_batch(1, 1, -1);
    wait_drain();
    chk("t_bp_count", got_q.size(), DEPTH);
    rdy_mode = 0;

    // Reset at word 7, then a fresh batch.
    wr_bias(0, 5); wr_bias(1, 6);
    for (int j = 0; j < DEPTH; j++) wdat[j] = PSUM_W'(j * 3);
    send_batch(1, 0, 7);
    wr_bias(1, 20); set_shift(0);
    got_q.delete();
    send_batch(1, 1, -1);
    wait_drain();
    chk("t_abort_count", got_q.size(), DEPTH);
    if (got_q.size() == DEPTH) begin
      chk("t_abort_lit0", got_q[0], 0);
      chk("t_abort_lit8", got_q[8], 44);
    end

    // Accumulator wrap to the most negative value.
    wr_bias(0, 0); wr_bias(1, 0);
    for (int j = 0; j < DEPTH; j++) wdat[j] = 32'h7FFF_FFFF;
    got_q.delete();
    send_batch(1, 0, -1);
    for (int j = 0; j < DEPTH; j++) wdat[j] = 32'd1;
    send_batch(0, 1, -1);
    chk("t_wrap_buf", mbuf[0], 32'h8000_0000);
    wait_drain();
    chk("t_wrap_count", got_q.size(), DEPTH);
    for (int j = 0; j < got_q.size(); j++) chk("t_wrap_lit", got_q[j], 0);

    // Random layers.
    for (int b = 0; b < 14; b++) begin
      int ng;
      ng = $urandom_range(1, 3);
      rdy_mode = $urandom_range(0, 2);
      for (int k = 0; k < KERNEL_NUM; k++) wr_bias(k, int'($urandom_range(0, 4000)) - 2000);
      set_shift(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 10));
      for (int g = 0; g < ng; g++) begin
        for (int j = 0; j < DEPTH; j++)
          wdat[j] = (b % 3 == 0) ? PSUM_W'($urandom)
                                 : PSUM_W'(int'($urandom_range(0, 6000)) - 3000);
        send_batch(g == 0, g == ng - 1, -1);
      end
      wait_drain();
    end
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
